reg_file16: RTL and testbench

Sixteen-entry, 16-bit general-purpose register file for the 16-bit processor datapath. It sits directly upstream of the 4-to-1 16-bit operand/writeback select muxes. It supplies two source operands per cycle (RD1, RD2) that drive mux data inputs. It accepts one writeback result per cycle, normally the output of the writeback select mux. Register 0 is hardwired to zero.

---
 rtl/reg_file16.sv | 53 +++++
 tb/tb_reg_file16.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_file16.sv
// reg_file16: 16 x 16-bit register file, two combinational read ports,
// one write port with same-cycle write-through bypass, R0 tied to zero.
module reg_file16 #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WE,
  input  logic [$clog2(NREGS)-1:0] WA,
  input  logic [WIDTH-1:0]         WD,
  input  logic [$clog2(NREGS)-1:0] RA1,
  input  logic [$clog2(NREGS)-1:0] RA2,
  output logic [WIDTH-1:0]         RD1,
  output logic [WIDTH-1:0]         RD2
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             wr_en;

  assign wr_en = WE && RST_N && (WA != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[WA] <= WD;
    end
  end

  // Bypass lets a same-cycle writeback reach the operand mux without a stall.
  function automatic logic [WIDTH-1:0] rd_sel(
    input logic [AW-1:0] ra
  );
    logic [WIDTH-1:0] v;
    v = '0;
    if (RST_N && ra != '0)
      v = (wr_en && WA == ra) ? WD : regs_q[ra];
    return v;
  endfunction

  always_comb begin
    RD1 = rd_sel(RA1);
    RD2 = rd_sel(RA2);
  end

  a_wr_known: assert property (
    @(posedge CLK) disable iff (!RST_N) !$isunknown({WE, WA})
  ) else $error("reg_file16: X/Z on WE/WA");

endmodule

// File: tb/tb_reg_file16.sv
// tb_reg_file16: scoreboard bench for reg_file16.
// Expected read data is queued with the stimulus and checked on drain.
module tb_reg_file16;

  logic        CLK;
  logic        RST_N;
  logic        WE;
  logic [3:0]  WA;
  logic [15:0] WD;
  logic [3:0]  RA1;
  logic [3:0]  RA2;
  logic [15:0] RD1;
  logic [15:0] RD2;

  reg_file16 dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .WE   (WE),
    .WA   (WA),
    .WD   (WD),
    .RA1  (RA1),
    .RA2  (RA2),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    bit          port;
    logic [15:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] model [16];
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit port,
                      input logic [15:0] exp);
    sb.push_back('{tag, port, exp});
  endtask

  task automatic drain();
    sb_t it;
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      chk(it.tag, it.port ? RD2 : RD1, it.exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge CLK);
    WE = 1'b1; WA = a; WD = d;
    @(negedge CLK);
    WE = 1'b0;
    if (a != 4'd0) model[a] = d;
  endtask

  task automatic rd(input string tag, input logic [3:0] a1,
                    input logic [3:0] a2);
    RA1 = a1; RA2 = a2;
    push({tag, "_rd1"}, 1'b0, (a1 == 0) ? 16'h0 : model[a1]);
    push({tag, "_rd2"}, 1'b1, (a2 == 0) ? 16'h0 : model[a2]);
    drain();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
  endtask

  initial begin
    checks = 0; failures = 0;
    model_clear();
    RST_N = 1'b0; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;
    repeat (2) @(negedge CLK);
    rd("rst_state", 4'd5, 4'd15);
    RST_N = 1'b1;
    @(negedge CLK);

    // async reset mid-cycle
    wr(4'd5, 16'h1234);
    rd("pre_rst", 4'd5, 4'd5);
    #2 RST_N = 1'b0;
    model_clear();
    rd("async_rst", 4'd5, 4'd5);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    rd("post_rst", 4'd5, 4'd5);

    // basic write/read
    wr(4'd3, 16'hBEEF);
    rd("basic", 4'd3, 4'd3);
    rd("basic_r4", 4'd4, 4'd3);

    // R0 hardwired, including during the write
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      WE = 1'b1; WA = 4'd0; WD = 16'hFFFF;
      RA1 = 4'd0; RA2 = 4'd3;
      push("r0_wr", 1'b0, 16'h0);
      push("r0_wr_p2", 1'b1, 16'hBEEF);
      drain();
      @(negedge CLK);
    end
    WE = 1'b0;
    rd("r0_after", 4'd0, 4'd0);

    // bypass
    wr(4'd7, 16'h1111);
    wr(4'd8, 16'h0808);
    WE = 1'b1; WA = 4'd7; WD = 16'h2222;
    RA1 = 4'd7; RA2 = 4'd8;
    push("byp_rd1", 1'b0, 16'h2222);
    push("byp_rd2", 1'b1, 16'h0808);
    drain();
    RA2 = 4'd7;
    push("byp_p2", 1'b1, 16'h2222);
    drain();
    @(negedge CLK);
    WE = 1'b0;
    model[7] = 16'h2222;
    rd("byp_after", 4'd7, 4'd8);

    // WE gating then last write wins
    WE = 1'b0; WA = 4'd9; WD = 16'hAAAA;
    @(negedge CLK);
    rd("we_gate", 4'd9, 4'd9);
    @(negedge CLK);
    WE = 1'b1; WA = 4'd9; WD = 16'h0001;
    @(negedge CLK);
    WD = 16'h0002;
    @(negedge CLK);
    WE = 1'b0;
    model[9] = 16'h0002;
    rd("last_wins", 4'd9, 4'd7);

    // full sweep
    for (int i = 15; i >= 1; i--)
      wr(i[3:0], 16'hA000 + 16'(i));
    for (int i = 0; i < 16; i++)
      rd($sformatf("sweep%0d", i), i[3:0], 4'(16 - i));

    // bypass suppressed during reset
    @(negedge CLK);
    WE = 1'b1; WA = 4'd7; WD = 16'h5555;
    RA1 = 4'd7; RA2 = 4'd12;
    RST_N = 1'b0;
    push("rst_byp1", 1'b0, 16'h0);
    push("rst_byp2", 1'b1, 16'h0);
    drain();
    model_clear();
    @(negedge CLK);
    WE = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    rd("rst_clr", 4'd7, 4'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
